// File: rtl/fetcher_icache.sv
// fetcher_icache: instruction fetcher with a direct-mapped one-instruction-per-line cache.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   core_state            scheduler state, a fetch is requested while it equals 3'b001
//   current_pc            address to fetch, held stable while fetching
//   cache_flush           one-cycle pulse that invalidates every line
//   mem_read_valid/address/ready/data   program memory read channel used on misses
//   fetcher_state         IDLE 3'b000, FETCHING 3'b001, FETCHED 3'b010
//   instruction           last fetched instruction, held until the next fetch completes
//   hit_count/miss_count  saturating lookup counters (COUNT_BITS wide, 16 by default)
module fetcher_icache #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 16,
    parameter int COUNT_BITS            = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;
    localparam int IB = $clog2(CACHE_LINES);
    localparam int TB = AW - IB;
    localparam logic [2:0] FETCH = 3'b001;

    typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          instr_q, instr_d;
    logic [CACHE_LINES-1:0] valid_q, valid_d;
    logic [COUNT_BITS-1:0]  hit_q, hit_d, miss_q, miss_d;
    logic [TB-1:0]          tag_q [CACHE_LINES];
    logic [DW-1:0]          data_q [CACHE_LINES];
    logic [IB-1:0]          idx, fill_idx;
    logic [TB-1:0]          tag, fill_tag;
    logic                   hit, fill;

    assign idx      = current_pc[IB-1:0];
    assign tag      = current_pc[AW-1:IB];
    // The fill targets the latched request address, so a pc change mid-fill cannot misplace the line.
    assign fill_idx = addr_q[IB-1:0];
    assign fill_tag = addr_q[AW-1:IB];
    assign hit      = valid_q[idx] && tag_q[idx] == tag;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        valid_d = cache_flush ? '0 : valid_q;
        fill    = 1'b0;
        case (state_q)
            IDLE: if (core_state == FETCH) begin
                if (hit && !cache_flush) begin
                    instr_d = data_q[idx];
                    state_d = FETCHED;
                    hit_d   = hit_q + COUNT_BITS'(hit_q != '1);
                end else begin
                    state_d = FETCHING;
                    req_d   = 1'b1;
                    addr_d  = current_pc;
                    miss_d  = miss_q + COUNT_BITS'(miss_q != '1);
                end
            end
            FETCHING: if (mem_read_ready) begin
                instr_d           = mem_read_data;
                req_d             = 1'b0;
                state_d           = FETCHED;
                // A flush landing with the data wins: deliver it but do not install it.
                fill              = !cache_flush;
                valid_d[fill_idx] = valid_d[fill_idx] | fill;
            end
            FETCHED: if (core_state != FETCH) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_read_data;
        end
    end

    assign mem_read_valid   = req_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign hit_count        = hit_q;
    assign miss_count       = miss_q;
endmodule

// File: tb/tb_fetcher_icache.sv
// tb_fetcher_icache: random fetch traffic against a line-occupancy model of the cache.
module tb_fetcher_icache;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LINES = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    core_state = 3'b000;
    logic [AW-1:0] current_pc = '0;
    logic          cache_flush = 1'b0;
    logic          mem_read_ready = 1'b0;
    logic [DW-1:0] mem_read_data = '0;

    logic          mem_read_valid, mem_read_valid_s;
    logic [AW-1:0] mem_read_address, mem_read_address_s;
    logic [2:0]    fetcher_state, fetcher_state_s;
    logic [DW-1:0] instruction, instruction_s;
    logic [15:0]   hit_count, miss_count;
    logic [3:0]    hit_count_s, miss_count_s;

    fetcher_icache dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .cache_flush(cache_flush), .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
        .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter twin on the same stimulus so saturation is reached within a short run.
    fetcher_icache #(.COUNT_BITS(4)) dut_sat (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .cache_flush(cache_flush), .mem_read_valid(mem_read_valid_s),
        .mem_read_address(mem_read_address_s), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetcher_state(fetcher_state_s),
        .instruction(instruction_s), .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    bit            line_ok [LINES];
    logic [AW-1:0] line_pc [LINES];
    int            hits = 0, misses = 0;
    int            n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return v > m ? m : v;
    endfunction

    task automatic chk_io(input string tag, input logic [2:0] st, input logic req, input logic [AW-1:0] addr);
        chk({tag, "_state"}, fetcher_state, st);
        chk({tag, "_state_s"}, fetcher_state_s, st);
        chk({tag, "_valid"}, mem_read_valid, req);
        chk({tag, "_valid_s"}, mem_read_valid_s, req);
        if (req) chk({tag, "_addr"}, mem_read_address, addr);
    endtask

    task automatic chk_instr(input string tag, input logic [DW-1:0] exp);
        chk({tag, "_instr"}, instruction, exp);
        chk({tag, "_instr_s"}, instruction_s, exp);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hits"}, hit_count, sat(hits, 65535));
        chk({tag, "_misses"}, miss_count, sat(misses, 65535));
        chk({tag, "_hits_s"}, hit_count_s, sat(hits, 15));
        chk({tag, "_misses_s"}, miss_count_s, sat(misses, 15));
    endtask

    task automatic forget_all();
        foreach (line_ok[i]) line_ok[i] = 1'b0;
    endtask

    task automatic flush_pulse();
        cache_flush = 1'b1;
        @(posedge clk); #1;
        cache_flush = 1'b0;
        forget_all();
        chk_io("flush", 3'b000, 1'b0, '0);
    endtask

    // Full fetch: request, optional memory wait, completion, then release back to IDLE.
    task automatic fetch(input logic [AW-1:0] pc, input int w, input bit fl_start, input bit fl_ready);
        int idx = int'(pc) % LINES;
        bit is_hit;
        if (fl_start) forget_all();
        is_hit = line_ok[idx] && line_pc[idx] == pc;
        core_state = 3'b001;
        current_pc = pc;
        cache_flush = fl_start;
        @(posedge clk); #1;
        cache_flush = 1'b0;
        if (is_hit) begin
            hits++;
            chk_io("hit", 3'b010, 1'b0, '0);
            chk_instr("hit", mem[pc]);
        end else begin
            misses++;
            chk_io("miss_req", 3'b001, 1'b1, pc);
            repeat (w) begin
                mem_read_ready = 1'b0;
                mem_read_data = DW'($urandom);
                @(posedge clk); #1;
                chk_io("miss_wait", 3'b001, 1'b1, pc);
            end
            mem_read_ready = 1'b1;
            mem_read_data = mem[pc];
            cache_flush = fl_ready;
            @(posedge clk); #1;
            mem_read_ready = 1'b0;
            cache_flush = 1'b0;
            if (fl_ready) forget_all();
            else begin
                line_ok[idx] = 1'b1;
                line_pc[idx] = pc;
            end
            chk_io("miss_done", 3'b010, 1'b0, '0);
            chk_instr("miss_done", mem[pc]);
        end
        chk_counts("fetch");
        core_state = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b010;
        mem_read_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
        mem_read_ready = 1'b0;
        chk_io("release", 3'b000, 1'b0, '0);
        chk_instr("release", mem[pc]);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = DW'($urandom);
        mem[8'h03] = 16'hA1B2;
        mem[8'h13] = 16'h1111;
        forget_all();
        #2;
        chk_io("por", 3'b000, 1'b0, '0);
        chk("por_addr", mem_read_address, 0);
        chk_instr("por", '0);
        chk_counts("por");
        @(posedge clk); #1;
        reset = 1'b0;
        fetch(8'h03, 3, 1'b0, 1'b0);
        fetch(8'h03, 0, 1'b0, 1'b0);
        fetch(8'h13, 1, 1'b0, 1'b0);
        fetch(8'h03, 0, 1'b0, 1'b0);
        fetch(8'h07, 0, 1'b0, 1'b0);
        flush_pulse();
        fetch(8'h07, 1, 1'b0, 1'b0);
        fetch(8'h07, 0, 1'b0, 1'b0);
        fetch(8'h07, 2, 1'b1, 1'b0);
        fetch(8'h17, 1, 1'b0, 1'b1);
        fetch(8'h17, 0, 1'b0, 1'b0);
        core_state = 3'b001;
        current_pc = 8'h20;
        @(posedge clk); #1;
        chk_io("pre_reset", 3'b001, 1'b1, 8'h20);
        #2;
        reset = 1'b1;
        #1;
        hits = 0;
        misses = 0;
        forget_all();
        chk_io("async_reset", 3'b000, 1'b0, '0);
        chk("async_reset_addr", mem_read_address, 0);
        chk_instr("async_reset", '0);
        chk_counts("async_reset");
        core_state = 3'b000;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data = 16'hDEAD;
        @(posedge clk); #1;
        mem_read_ready = 1'b0;
        chk_io("stale_ready", 3'b000, 1'b0, '0);
        chk_instr("stale_ready", '0);
        fetch(8'h05, 0, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) flush_pulse();
            fetch(AW'($urandom_range(0, 47)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end
        fetch(8'h09, 1, 1'b0, 1'b0);
        repeat (20) fetch(8'h09, 0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
